seq_div32by16: RTL and testbench



---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 31 +++
 rtl/seq_div32by16.sv | 191 +++++++++++++++++++
 tb/tb_seq_div32by16.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Used by div_step and seq_div32by16.
`timescale 1ns/1ps
package div_pkg;

    // Default operand width: 32-bit dividend, 16-bit divisor/quotient/remainder.
    localparam int W_DEFAULT = 16;

    // Step counter width for the default width. It can hold the value W.
    localparam int CNT_W_DEFAULT = $clog2(W_DEFAULT) + 1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Step counter width for a given operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   The current partial remainder is shifted left, and the next dividend
//   bit enters at the lsb. The divisor is then trial-subtracted from it.
//   If the subtraction does not borrow, the difference is kept and the
//   quotient bit is 1.
// The incoming remainder is always below the divisor, so it fits in W bits.
// Only the shifted value needs the extra (W+1-th) bit.
`timescale 1ns/1ps
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] r_in,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_out,
    output logic         q_bit
);

    logic [W:0]   r_sh;
    logic [W-1:0] t;

    // Shift, trial subtract, then restore or keep.
    always_comb begin
        r_sh  = {r_in, q_msb};
        q_bit = (r_sh >= {1'b0, divisor});
        // The subtraction modulo 2^W is exact whenever it is kept (no borrow).
        t     = r_sh[W-1:0] - divisor;
        r_out = q_bit ? t : r_sh[W-1:0];
    end

endmodule

// File: rtl/seq_div32by16.sv
// Sequential unsigned restoring divider: a 2W-bit dividend divided by a
// W-bit divisor gives a W-bit quotient and a W-bit remainder.
// It has valid/ready handshakes on both the operand side and the result side.
//
// Build option: define DIV_RADIX4_EN to chain two div_step instances per
// CALC cycle. This halves the iteration count (W must be even). Results
// are bit-identical to the default radix-2 build.
//
// Divide-by-zero and quotient overflow are caught when operands are
// accepted. In that case the divider goes straight to DONE with err set.
`timescale 1ns/1ps
import div_pkg::*;

module seq_div32by16 #(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           err
);

    localparam int CNT_W = cnt_width(W);
`ifdef DIV_RADIX4_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    div_state_e state_q, state_d;

    // Working registers. The remainder register is W bits wide because a
    // restored remainder is always below the divisor.
    logic [W-1:0]     r_q,    r_d;
    logic [W-1:0]     q_q,    q_d;
    logic [W-1:0]     div_q,  div_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    // Result registers. They load only on entry to DONE, so a partial
    // quotient never appears on the outputs.
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_q,  rem_d;
    logic             err_q,  err_d;

    logic             accept;
    logic             ovf;
    logic             last_step;
    logic [W-1:0]     r_step;
    logic [W-1:0]     q_step;

    assign accept    = in_valid && (state_q == IDLE);
    // A zero divisor is caught here too, because any high half is >= 0.
    assign ovf       = (dividend[2*W-1:W] >= divisor);
    assign last_step = (cnt_q == LAST_CNT);

`ifdef DIV_RADIX4_EN
    logic [W-1:0] r_mid;
    logic         qb_hi;
    logic         qb_lo;

    div_step #(.W(W)) u_step_hi (
        .r_in    (r_q),
        .q_msb   (q_q[W-1]),
        .divisor (div_q),
        .r_out   (r_mid),
        .q_bit   (qb_hi)
    );

    div_step #(.W(W)) u_step_lo (
        .r_in    (r_mid),
        .q_msb   (q_q[W-2]),
        .divisor (div_q),
        .r_out   (r_step),
        .q_bit   (qb_lo)
    );

    // Two dividend bits leave the top of Q, and two quotient bits enter at the bottom.
    assign q_step = W'({q_q, qb_hi, qb_lo});
`else
    logic qb;

    div_step #(.W(W)) u_step (
        .r_in    (r_q),
        .q_msb   (q_q[W-1]),
        .divisor (div_q),
        .r_out   (r_step),
        .q_bit   (qb)
    );

    // One dividend bit leaves the top of Q, and one quotient bit enters at the bottom.
    assign q_step = W'({q_q, qb});
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: error operands skip CALC, and DONE waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = ovf ? DONE : CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load at accept, iterate in CALC, capture the result at the end.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    div_d = divisor;
                    cnt_d = '0;
                    if (ovf) begin
                        quot_d = '1;
                        rem_d  = dividend[W-1:0];
                        err_d  = 1'b1;
                    end else begin
                        r_d = dividend[2*W-1:W];
                        q_d = dividend[W-1:0];
                    end
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    quot_d = q_step;
                    rem_d  = r_step;
                    err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            q_q    <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            err_q  <= err_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_div32by16.sv
// Directed and randomized checks for seq_div32by16 (W=16).
`timescale 1ns/1ps
module tb_seq_div32by16;

    localparam int W = 16;
`ifdef DIV_RADIX4_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           err;

    int errors = 0;
    int checks = 0;

    seq_div32by16 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge once in_ready is high, then let
    // the next rising edge accept them. After that edge the inputs are
    // scrambled, so a design that uses the live inputs instead of its
    // latched copy will be caught.
    task automatic start(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = W'($urandom);
    endtask

    // Called just after the accept edge. The accept edge itself counts as
    // clock 1. The wait is bounded, and a timeout shows up as a latency
    // or out_valid failure.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                       input int elat);
        int lat;
        start(dvd, dvs);
        wait_result(lat);
        chk({tag, "_lat"},       64'(lat),       64'(elat));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_quotient"},  64'(quotient),  64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_err"},       64'(err),       64'(ee));
        @(posedge clk);
        #1;
        chk({tag, "_in_ready_after"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [2*W-1:0] rd;
        logic [W-1:0]   rs;
        logic [63:0]    recon;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient",  64'(quotient),  64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_err",       64'(err),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic case, and the cases with the largest quotients.
        run("d100_7",    32'd100,       16'd7,      16'd14,     16'd2,      1'b0, LAT);
        run("dmax",      32'hFFFE_0001, 16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, LAT);
        run("d1234",     32'h1234_5678, 16'h1235,   16'hFFF6,   16'h0C8A,   1'b0, LAT);
        // Error path: divide by zero, then quotient overflow (high half == divisor).
        run("div0",      32'h0000_ABCD, 16'h0000,   16'hFFFF,   16'hABCD,   1'b1, 1);
        run("ovf",       32'h0007_0000, 16'h0007,   16'hFFFF,   16'h0000,   1'b1, 1);

        // Backpressure: the result must hold while out_ready is low.
        out_ready = 1'b0;
        start(32'd1000, 16'd3);
        wait_result(lat);
        chk("bp_lat", 64'(lat),      64'(LAT));
        chk("bp_q",   64'(quotient), 64'd333);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            dividend = $urandom & 32'h0000_FFFF;
            divisor  = W'($urandom_range(1, 65535));
            @(posedge clk);
            #1;
            chk("bp_hold_q",         64'(quotient),  64'd333);
            chk("bp_hold_r",         64'(remainder), 64'd1);
            chk("bp_hold_err",       64'(err),       64'd0);
            chk("bp_hold_out_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_in_ready",  64'(in_ready),  64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 32'd100;
        divisor   = 16'd7;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready",  64'(in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", 64'(in_ready), 64'd0);
        wait_result(lat);
        chk("bp_next_lat", 64'(lat),       64'(LAT));
        chk("bp_next_q",   64'(quotient),  64'd14);
        chk("bp_next_r",   64'(remainder), 64'd2);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC aborts the operation immediately.
        start(32'd1000, 16'd3);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_quotient",  64'(quotient),  64'd0);
        chk("midrst_remainder", 64'(remainder), 64'd0);
        chk("midrst_err",       64'(err),       64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run("d1000_3", 32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, LAT);

        // Random legal operands: check the division invariant on every result.
        for (int i = 0; i < 2000; i++) begin
            rs = W'($urandom_range(1, 65535));
            rd = {W'($urandom % rs), W'($urandom)};
            start(rd, rs);
            wait_result(lat);
            recon = 64'(quotient) * 64'(rs) + 64'(remainder);
            chk("rand_out_valid", 64'(out_valid),       64'd1);
            chk("rand_recon",     recon,                64'(rd));
            chk("rand_rem_lt",    64'(remainder < rs),  64'd1);
            chk("rand_err",       64'(err),             64'd0);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
